// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: payload + control vector with valid/ready
// handshake, stall, synchronous flush and an optional registered-ready skid entry.
module pipe_stage_reg #(
  parameter int DATA_W = 167,
  parameter int CTRL_W = 12,
  parameter int SKID   = 1
) (
  input  logic              clkIn,
  input  logic              resetn,
  input  logic              flushIn,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] dataIn,
  input  logic [CTRL_W-1:0] ctrlIn,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] dataOut,
  output logic [CTRL_W-1:0] ctrlOut,
  output logic [1:0]        occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, stateNxt;

  logic inRdyReg, inRdyNxt;
  logic loadH, loadS, moveS;
  logic accept, emit;
  logic vld_p0, vld_p1;

  logic [DATA_W-1:0] hData_p0;
  logic [CTRL_W-1:0] hCtrl_p0;
  logic [DATA_W-1:0] sData_p1;
  logic [CTRL_W-1:0] sCtrl_p1;

  // Head entry valid whenever anything is held; skid entry valid only when full.
  assign vld_p0 = (state != EMPTY);
  assign vld_p1 = (state == FULL);

  // In skid mode the ready comes straight from a flop so the downstream stall
  // never ripples through this stage; single-entry mode passes it through.
  assign inReady  = (SKID != 0) ? inRdyReg : (~vld_p0 | outReady);
  assign accept   = inValid & inReady;
  assign emit     = vld_p0 & outReady;

  assign outValid = vld_p0;
  assign dataOut  = hData_p0;
  assign ctrlOut  = vld_p0 ? hCtrl_p0 : '0;
  assign occ      = {vld_p1, vld_p0 & ~vld_p1};

  // Next-state and entry load decisions from the handshake; flush overrides.
  always_comb begin
    stateNxt = state;
    loadH    = 1'b0;
    loadS    = 1'b0;
    moveS    = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          stateNxt = BUSY;
          loadH    = 1'b1;
        end
      end
      BUSY: begin
        if (accept && emit) begin
          loadH = 1'b1;
        end else if (accept) begin
          if (SKID != 0) begin
            stateNxt = FULL;
            loadS    = 1'b1;
          end else begin
            loadH = 1'b1;
          end
        end else if (emit) begin
          stateNxt = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          stateNxt = BUSY;
          moveS    = 1'b1;
        end
      end
      default: stateNxt = EMPTY;
    endcase
    if (flushIn) begin
      stateNxt = EMPTY;
      loadH    = 1'b0;
      loadS    = 1'b0;
      moveS    = 1'b0;
    end
    inRdyNxt = (stateNxt != FULL);
  end

  // Control state and registered ready; reset wins over flush and handshake.
  always_ff @(posedge clkIn) begin
    if (!resetn) begin
      state    <= EMPTY;
      inRdyReg <= 1'b1;
    end else begin
      state    <= stateNxt;
      inRdyReg <= inRdyNxt;
    end
  end

  // Payload storage: head loads from input or is refilled from the skid entry.
  always_ff @(posedge clkIn) begin
    if (!resetn) begin
      hData_p0 <= '0;
      hCtrl_p0 <= '0;
      sData_p1 <= '0;
      sCtrl_p1 <= '0;
    end else begin
      if (loadH) begin
        hData_p0 <= dataIn;
        hCtrl_p0 <= ctrlIn;
      end else if (moveS) begin
        hData_p0 <= sData_p1;
        hCtrl_p0 <= sCtrl_p1;
      end
      if (loadS) begin
        sData_p1 <= dataIn;
        sCtrl_p1 <= ctrlIn;
      end
    end
  end

endmodule
